axi_bus_arbiter: RTL and testbench
==================================

// Module: axi_bus_arbiter
// PURPOSE
// - Shares one AXI3 master port between icache (read only, port i_) and the dcache AXI engine (read+write, port d_).
// - Reads: 2-way arbitration, one burst outstanding, channel locked to winner until rlast handshake.
// - Writes: dcache only, one burst outstanding; blocks dcache reads that hit the line of an unacknowledged write.
// - Sits between the cache AXI engines and the SoC crossbar at CPU top level.
// PARAMETERS
// - ID_W        4  AXI id width
// - LINE_OFF_W  5  low address bits ignored in hazard compare (32-byte line)
// - STARVE_MAX  4  consecutive dcache read grants won while icache waited before icache is forced
// PORTS
// aclk                        in   1       clock, all state on rising edge
// areset                      in   1       asynchronous, active-high reset
// i_araddr/i_arlen/i_arsize   in   32/4/3  icache read request fields
// i_arvalid / i_arready       in/out 1     icache AR handshake
// i_rdata/i_rlast/i_rvalid    out  32/1/1  icache read data
// i_rready                    in   1       icache read data accept
// d_araddr/d_arlen/d_arsize   in   32/4/3  dcache read request fields
// d_arvalid / d_arready       in/out 1     dcache AR handshake
// d_rdata/d_rlast/d_rvalid    out  32/1/1  dcache read data
// d_rready                    in   1       dcache read data accept
// d_awaddr/awlen/awsize/awvalid in 32/4/3/1  dcache write address; d_awready out 1
// d_wdata/wstrb/wlast/wvalid  in   32/4/1/1  dcache write data; d_wready out 1
// d_bvalid / d_bready         out/in 1     dcache write response
// m_arid/araddr/arlen/arsize/arvalid out ID_W/32/4/3/1; m_arready in 1
// m_rid/rdata/rlast/rvalid    in   ID_W/32/1/1; m_rready out 1
// m_awid/awaddr/awlen/awsize/awvalid out ID_W/32/4/3/1; m_awready in 1
// m_wid/wdata/wstrb/wlast/wvalid out ID_W/32/4/1/1; m_wready in 1
// m_bvalid in 1; m_bready out 1
// BEHAVIOUR
// - Reset: read FSM R_IDLE, write FSM W_IDLE, starve_cnt 0, pend_valid 0; every valid/ready output 0, m_ar* fields 0.
// - IDs: icache 0, dcache 1 (m_arid per owner; m_awid = m_wid = 1). burst/lock/cache/prot are driven downstream.
// - Read FSM R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
//   R_IDLE: eligible I = i_arvalid; eligible D = d_arvalid & !hazard. Both eligible: D wins unless starve_cnt == STARVE_MAX.
//   On grant: latch owner+addr/len/size, pulse winner's arready for 1 cycle, next state R_ADDR (1-cycle arb latency).
//   R_ADDR: m_arvalid=1 with latched fields, held stable until m_arready; handshake -> R_DATA.
//   R_DATA: m_r* routed to owner, m_rready = owner rready; non-owner rvalid = 0. rvalid&rready&rlast -> R_IDLE.
//   No re-arbitration in the rlast cycle; next grant earliest in the cycle after.
// - starve_cnt: +1 (saturating) on a D grant while i_arvalid=1; cleared on any I grant.
// - Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
//   W_IDLE: AW combinationally passed through (m_awvalid = d_awvalid, d_awready = m_awready); handshake latches
//     awaddr into pend_addr, sets pend_valid, -> W_DATA.
//   W_DATA: W passed through; wvalid/wready forced 0 in all other states. wvalid&wready&wlast -> W_RESP.
//   W_RESP: B passed through; bvalid&bready -> W_IDLE, clears pend_valid.
// - hazard = pend_valid & (d_araddr[31:LINE_OFF_W] == pend_addr[31:LINE_OFF_W]). Uses registered pend_valid,
//   so a D read stays blocked in the B-handshake cycle and is granted at the earliest one cycle later.
// - Read and write FSMs are independent; an I read proceeds while a D write is in any state.
// - Reset mid-burst: both FSMs return to idle, pending state is discarded; the slave shares this reset domain.
// STRUCTURE
// - defines.v: one-hot read/write state encodings plus `AXI_ID_ICACHE 4'd0 / `AXI_ID_DCACHE 4'd1.
// - One sub-module: axi_wr_tracker (write FSM, pend_addr/pend_valid, hazard output). Read FSM stays in top.
// TESTING
// - Lone I read 0x1FC0_0000 len 7: i_arready pulse, m_arid 0, 8 beats reach i_r*, d_rvalid stays 0.
// - I and D arvalid in same cycle, starve_cnt 0: D granted (m_arid 1); I granted after D's rlast.
// - D floods back-to-back reads while I waits: 5th grant goes to I (STARVE_MAX 4), starve_cnt back to 0.
// - D write 0x0000_1000 in flight, then D read 0x0000_1014: read held until the cycle after b handshake;
//   D read 0x0000_1020 (other line) is granted during the write.
// - Write 8 beats with m_wready toggling every cycle: exactly 8 W handshakes, wlast on the 8th, then W_RESP.
// - areset asserted during R_DATA beat 3: all valid outputs 0 immediately, FSMs idle, fresh I read completes.

Source files
------------

// File: rtl/axi_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// axi_bus_arbiter_pkg
// Shared types and constants for the AXI3 bus arbiter that lets the icache
// and the dcache engine share one master port.
//   readState_t  : one-hot read FSM encoding (idle / address / data)
//   writeState_t : one-hot write FSM encoding (idle / data / response)
//   readOwner_t  : which cache currently owns the read channel
//   AXI_ID_*     : fixed AXI ids presented downstream for each cache
// ----------------------------------------------------------------------------
package axi_bus_arbiter_pkg;

   typedef enum logic [2:0] {
      R_IDLE = 3'b001,
      R_ADDR = 3'b010,
      R_DATA = 3'b100
   } readState_t;

   typedef enum logic [2:0] {
      W_IDLE = 3'b001,
      W_DATA = 3'b010,
      W_RESP = 3'b100
   } writeState_t;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } readOwner_t;

   localparam logic [3:0] AXI_ID_ICACHE = 4'd0;
   localparam logic [3:0] AXI_ID_DCACHE = 4'd1;

endpackage

// File: rtl/axi_bus_arbiter_wr_tracker.sv
// ----------------------------------------------------------------------------
// axi_bus_arbiter_wr_tracker
// Write-side path of the arbiter. Only the dcache writes, so AW/W/B are passed
// straight through, gated by a small FSM that allows one burst in flight. The
// line address of the in-flight write is remembered until its B response so
// that dcache reads to the same line can be held off.
// Ports:
//   aclk, areset                  clock, async active-high reset
//   d_aw*/d_w*/d_b*               dcache write channels (slave side)
//   m_aw*/m_w*/m_b*               downstream write channels (master side)
//   i_rdLine                      line part of the current dcache read address
//   o_hazard                      read line matches an unacknowledged write
// ----------------------------------------------------------------------------
module axi_bus_arbiter_wr_tracker
   import axi_bus_arbiter_pkg::*;
#(
   parameter int ID_W       = 4,
   parameter int LINE_OFF_W = 5
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [31:0]           d_awaddr,
   input  logic [3:0]            d_awlen,
   input  logic [2:0]            d_awsize,
   input  logic                  d_awvalid,
   output logic                  d_awready,
   input  logic [31:0]           d_wdata,
   input  logic [3:0]            d_wstrb,
   input  logic                  d_wlast,
   input  logic                  d_wvalid,
   output logic                  d_wready,
   output logic                  d_bvalid,
   input  logic                  d_bready,
   output logic [ID_W-1:0]       m_awid,
   output logic [31:0]           m_awaddr,
   output logic [3:0]            m_awlen,
   output logic [2:0]            m_awsize,
   output logic                  m_awvalid,
   input  logic                  m_awready,
   output logic [ID_W-1:0]       m_wid,
   output logic [31:0]           m_wdata,
   output logic [3:0]            m_wstrb,
   output logic                  m_wlast,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   input  logic                  m_bvalid,
   output logic                  m_bready,
   input  logic [31-LINE_OFF_W:0] i_rdLine,
   output logic                  o_hazard
);

   writeState_t                 r_writeState;
   writeState_t                 w_writeNext;
   logic [31-LINE_OFF_W:0]      r_pendLine;
   logic                        r_pendValid;
   logic                        w_awHs;
   logic                        w_bHs;

   // Payload fields flow through unchanged; only the handshakes are gated.
   assign m_awid   = ID_W'(AXI_ID_DCACHE);
   assign m_awaddr = d_awaddr;
   assign m_awlen  = d_awlen;
   assign m_awsize = d_awsize;
   assign m_wid    = ID_W'(AXI_ID_DCACHE);
   assign m_wdata  = d_wdata;
   assign m_wstrb  = d_wstrb;
   assign m_wlast  = d_wlast;

   // The hazard uses the registered pending flag, so a same-line read is
   // still blocked during the cycle in which the B handshake happens.
   assign o_hazard = r_pendValid & (i_rdLine == r_pendLine);

   // Each channel is connected only in the state that owns it; everything
   // else is held at zero so a stray valid cannot leak downstream.
   always_comb begin
      w_writeNext = r_writeState;
      m_awvalid   = 1'b0;
      d_awready   = 1'b0;
      m_wvalid    = 1'b0;
      d_wready    = 1'b0;
      d_bvalid    = 1'b0;
      m_bready    = 1'b0;
      w_awHs      = 1'b0;
      w_bHs       = 1'b0;
      unique case (r_writeState)
         W_IDLE: begin
            m_awvalid = d_awvalid;
            d_awready = m_awready;
            w_awHs    = d_awvalid & m_awready;
            if (w_awHs) w_writeNext = W_DATA;
         end
         W_DATA: begin
            m_wvalid = d_wvalid;
            d_wready = m_wready;
            if (d_wvalid && m_wready && d_wlast) w_writeNext = W_RESP;
         end
         W_RESP: begin
            d_bvalid = m_bvalid;
            m_bready = d_bready;
            w_bHs    = m_bvalid & d_bready;
            if (w_bHs) w_writeNext = W_IDLE;
         end
         default: w_writeNext = W_IDLE;
      endcase
   end

   // State register plus the pending-line record that lives from the AW
   // handshake until the B handshake.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_writeState <= W_IDLE;
         r_pendLine   <= '0;
         r_pendValid  <= 1'b0;
      end else begin
         r_writeState <= w_writeNext;
         if (w_awHs) begin
            r_pendLine  <= d_awaddr[31:LINE_OFF_W];
            r_pendValid <= 1'b1;
         end else if (w_bHs) begin
            r_pendValid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/axi_bus_arbiter.sv
// ----------------------------------------------------------------------------
// axi_bus_arbiter
// Shares one AXI3 master port between the icache (read only, i_*) and the
// dcache engine (read and write, d_*). Reads are arbitrated two ways with one
// burst outstanding and the read channel locked to the winner until rlast.
// The dcache normally wins, but after STARVE_MAX consecutive dcache wins with
// the icache waiting, the icache is forced through. Writes come from the
// dcache only and are handled by the write tracker sub-module.
// Ports:
//   aclk, areset                 clock, async active-high reset
//   i_ar*/i_r*                   icache read address / data
//   d_ar*/d_r*                   dcache read address / data
//   d_aw*/d_w*/d_b*              dcache write channels
//   m_ar*/m_r*/m_aw*/m_w*/m_b*   shared downstream AXI3 master port
// ----------------------------------------------------------------------------
module axi_bus_arbiter
   import axi_bus_arbiter_pkg::*;
#(
   parameter int ID_W       = 4,
   parameter int LINE_OFF_W = 5,
   parameter int STARVE_MAX = 4
) (
   input  logic            aclk,
   input  logic            areset,
   input  logic [31:0]     i_araddr,
   input  logic [3:0]      i_arlen,
   input  logic [2:0]      i_arsize,
   input  logic            i_arvalid,
   output logic            i_arready,
   output logic [31:0]     i_rdata,
   output logic            i_rlast,
   output logic            i_rvalid,
   input  logic            i_rready,
   input  logic [31:0]     d_araddr,
   input  logic [3:0]      d_arlen,
   input  logic [2:0]      d_arsize,
   input  logic            d_arvalid,
   output logic            d_arready,
   output logic [31:0]     d_rdata,
   output logic            d_rlast,
   output logic            d_rvalid,
   input  logic            d_rready,
   input  logic [31:0]     d_awaddr,
   input  logic [3:0]      d_awlen,
   input  logic [2:0]      d_awsize,
   input  logic            d_awvalid,
   output logic            d_awready,
   input  logic [31:0]     d_wdata,
   input  logic [3:0]      d_wstrb,
   input  logic            d_wlast,
   input  logic            d_wvalid,
   output logic            d_wready,
   output logic            d_bvalid,
   input  logic            d_bready,
   output logic [ID_W-1:0] m_arid,
   output logic [31:0]     m_araddr,
   output logic [3:0]      m_arlen,
   output logic [2:0]      m_arsize,
   output logic            m_arvalid,
   input  logic            m_arready,
   input  logic [ID_W-1:0] m_rid,
   input  logic [31:0]     m_rdata,
   input  logic            m_rlast,
   input  logic            m_rvalid,
   output logic            m_rready,
   output logic [ID_W-1:0] m_awid,
   output logic [31:0]     m_awaddr,
   output logic [3:0]      m_awlen,
   output logic [2:0]      m_awsize,
   output logic            m_awvalid,
   input  logic            m_awready,
   output logic [ID_W-1:0] m_wid,
   output logic [31:0]     m_wdata,
   output logic [3:0]      m_wstrb,
   output logic            m_wlast,
   output logic            m_wvalid,
   input  logic            m_wready,
   input  logic            m_bvalid,
   output logic            m_bready
);

   localparam int STARVE_W = $clog2(STARVE_MAX + 1);

   readState_t            r_readState;
   readState_t            w_readNext;
   readOwner_t            r_owner;
   logic                  r_iArready;
   logic                  r_dArready;
   logic [STARVE_W-1:0]   r_starveCnt;
   logic                  w_hazard;
   logic                  w_grantI;
   logic                  w_grantD;
   logic                  w_rDone;
   logic                  w_ownerIsI;
   logic                  w_unusedRid;

   // Read data is owner-routed by the FSM, so the returned id is not needed.
   assign w_unusedRid = ^m_rid;

   assign w_ownerIsI = (r_owner == OWNER_I);
   assign i_arready  = r_iArready;
   assign d_arready  = r_dArready;
   assign m_arvalid  = (r_readState == R_ADDR);
   assign m_rready   = (r_readState == R_DATA) & (w_ownerIsI ? i_rready : d_rready);
   assign i_rvalid   = (r_readState == R_DATA) &  w_ownerIsI & m_rvalid;
   assign d_rvalid   = (r_readState == R_DATA) & ~w_ownerIsI & m_rvalid;
   assign i_rdata    = m_rdata;
   assign i_rlast    = m_rlast;
   assign d_rdata    = m_rdata;
   assign d_rlast    = m_rlast;
   assign w_rDone    = m_rvalid & m_rready & m_rlast;

   // Arbitration only happens in R_IDLE. The dcache wins ties unless the
   // icache has already been passed over STARVE_MAX times in a row. Because
   // the rlast cycle moves to R_IDLE rather than arbitrating, the next grant
   // is always at least one cycle after the previous burst ends.
   always_comb begin
      w_readNext = r_readState;
      w_grantI   = 1'b0;
      w_grantD   = 1'b0;
      unique case (r_readState)
         R_IDLE: begin
            if (d_arvalid && !w_hazard &&
                (!i_arvalid || r_starveCnt != STARVE_W'(STARVE_MAX)))
               w_grantD = 1'b1;
            else if (i_arvalid)
               w_grantI = 1'b1;
            if (w_grantI || w_grantD) w_readNext = R_ADDR;
         end
         R_ADDR:  if (m_arready) w_readNext = R_DATA;
         R_DATA:  if (w_rDone)   w_readNext = R_IDLE;
         default: w_readNext = R_IDLE;
      endcase
   end

   // Grant bookkeeping: latch the winner's request so m_ar* stays stable
   // during R_ADDR, raise the winner's arready for exactly one cycle, and
   // track how many dcache wins in a row have made the icache wait.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_readState <= R_IDLE;
         r_owner     <= OWNER_I;
         m_arid      <= '0;
         m_araddr    <= '0;
         m_arlen     <= '0;
         m_arsize    <= '0;
         r_iArready  <= 1'b0;
         r_dArready  <= 1'b0;
         r_starveCnt <= '0;
      end else begin
         r_readState <= w_readNext;
         r_iArready  <= w_grantI;
         r_dArready  <= w_grantD;
         if (w_grantD) begin
            r_owner  <= OWNER_D;
            m_arid   <= ID_W'(AXI_ID_DCACHE);
            m_araddr <= d_araddr;
            m_arlen  <= d_arlen;
            m_arsize <= d_arsize;
            if (i_arvalid && r_starveCnt != STARVE_W'(STARVE_MAX))
               r_starveCnt <= r_starveCnt + 1'b1;
         end else if (w_grantI) begin
            r_owner     <= OWNER_I;
            m_arid      <= ID_W'(AXI_ID_ICACHE);
            m_araddr    <= i_araddr;
            m_arlen     <= i_arlen;
            m_arsize    <= i_arsize;
            r_starveCnt <= '0;
         end
      end
   end

   axi_bus_arbiter_wr_tracker #(
      .ID_W       (ID_W),
      .LINE_OFF_W (LINE_OFF_W)
   ) u_wrTracker (
      .aclk      (aclk),
      .areset    (areset),
      .d_awaddr  (d_awaddr),
      .d_awlen   (d_awlen),
      .d_awsize  (d_awsize),
      .d_awvalid (d_awvalid),
      .d_awready (d_awready),
      .d_wdata   (d_wdata),
      .d_wstrb   (d_wstrb),
      .d_wlast   (d_wlast),
      .d_wvalid  (d_wvalid),
      .d_wready  (d_wready),
      .d_bvalid  (d_bvalid),
      .d_bready  (d_bready),
      .m_awid    (m_awid),
      .m_awaddr  (m_awaddr),
      .m_awlen   (m_awlen),
      .m_awsize  (m_awsize),
      .m_awvalid (m_awvalid),
      .m_awready (m_awready),
      .m_wid     (m_wid),
      .m_wdata   (m_wdata),
      .m_wstrb   (m_wstrb),
      .m_wlast   (m_wlast),
      .m_wvalid  (m_wvalid),
      .m_wready  (m_wready),
      .m_bvalid  (m_bvalid),
      .m_bready  (m_bready),
      .i_rdLine  (d_araddr[31:LINE_OFF_W]),
      .o_hazard  (w_hazard)
   );

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_bus_arbiter
// Directed bench for axi_bus_arbiter. Expected grants, read beats and write
// beats are queued when each request is issued; a monitor process pops and
// compares them whenever the DUT presents a handshake. A simple slave model
// answers the downstream AXI port.
// ----------------------------------------------------------------------------
module tb_axi_bus_arbiter;

   localparam int ID_W   = 4;
   localparam int BDELAY = 12;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [31:0]     addr;
      logic [3:0]      len;
   } arExp_t;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic            aclk;
   logic            areset;
   logic [31:0]     i_araddr;
   logic [3:0]      i_arlen;
   logic [2:0]      i_arsize;
   logic            i_arvalid;
   logic            i_arready;
   logic [31:0]     i_rdata;
   logic            i_rlast;
   logic            i_rvalid;
   logic            i_rready;
   logic [31:0]     d_araddr;
   logic [3:0]      d_arlen;
   logic [2:0]      d_arsize;
   logic            d_arvalid;
   logic            d_arready;
   logic [31:0]     d_rdata;
   logic            d_rlast;
   logic            d_rvalid;
   logic            d_rready;
   logic [31:0]     d_awaddr;
   logic [3:0]      d_awlen;
   logic [2:0]      d_awsize;
   logic            d_awvalid;
   logic            d_awready;
   logic [31:0]     d_wdata;
   logic [3:0]      d_wstrb;
   logic            d_wlast;
   logic            d_wvalid;
   logic            d_wready;
   logic            d_bvalid;
   logic            d_bready;
   logic [ID_W-1:0] m_arid;
   logic [31:0]     m_araddr;
   logic [3:0]      m_arlen;
   logic [2:0]      m_arsize;
   logic            m_arvalid;
   logic            m_arready;
   logic [ID_W-1:0] m_rid;
   logic [31:0]     m_rdata;
   logic            m_rlast;
   logic            m_rvalid;
   logic            m_rready;
   logic [ID_W-1:0] m_awid;
   logic [31:0]     m_awaddr;
   logic [3:0]      m_awlen;
   logic [2:0]      m_awsize;
   logic            m_awvalid;
   logic            m_awready;
   logic [ID_W-1:0] m_wid;
   logic [31:0]     m_wdata;
   logic [3:0]      m_wstrb;
   logic            m_wlast;
   logic            m_wvalid;
   logic            m_wready;
   logic            m_bvalid;
   logic            m_bready;

   arExp_t      grantQ[$];
   beat_t       iBeatQ[$];
   beat_t       dBeatQ[$];
   beat_t       wQ[$];
   logic [31:0] awQ[$];

   int compared;
   int mismatched;
   int cycle;
   int iArreadyCount;
   int iBeatsSeen;
   int wHsCount;
   int bHsCount;
   int bHsCycle;
   int dArreadyCycle;
   int d1020Cycle;
   logic awDone;

   axi_bus_arbiter #(.ID_W(ID_W), .LINE_OFF_W(5), .STARVE_MAX(4)) dut (
      .aclk(aclk), .areset(areset),
      .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
      .i_arvalid(i_arvalid), .i_arready(i_arready),
      .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
      .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
      .d_arvalid(d_arvalid), .d_arready(d_arready),
      .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
      .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize),
      .d_awvalid(d_awvalid), .d_awready(d_awready),
      .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
      .d_wvalid(d_wvalid), .d_wready(d_wready),
      .d_bvalid(d_bvalid), .d_bready(d_bready),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast),
      .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   // Free-running clock and cycle counter used for latency checks.
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      cycle = 0;
      forever begin
         @(posedge aclk);
         cycle++;
      end
   end

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic expectGrant(input logic [ID_W-1:0] id, input logic [31:0] addr,
                              input logic [3:0] len);
      arExp_t e;
      e.id = id; e.addr = addr; e.len = len;
      grantQ.push_back(e);
   endtask

   // Issue one read request on port 0 (icache) or 1 (dcache) and queue its
   // expected beats. Returns once the AR handshake has completed.
   task automatic applyStimulus(input int port, input logic [31:0] addr,
                                input logic [3:0] len);
      beat_t b;
      bit    seen;
      for (int k = 0; k <= int'(len); k++) begin
         b.data = addr + 32'(4 * k);
         b.last = (k == int'(len));
         if (port == 0) iBeatQ.push_back(b); else dBeatQ.push_back(b);
      end
      if (port == 0) begin
         i_araddr = addr; i_arlen = len; i_arsize = 3'd2; i_arvalid = 1'b1;
      end else begin
         d_araddr = addr; d_arlen = len; d_arsize = 3'd2; d_arvalid = 1'b1;
      end
      seen = 1'b0;
      for (int c = 0; c < 400 && !seen; c++) begin
         @(negedge aclk);
         seen = (port == 0) ? i_arready : d_arready;
      end
      if (!seen) checkOutput("arready_timeout", 32'(port), 32'hFFFF_FFFF);
      @(posedge aclk); #1;
      if (port == 0) i_arvalid = 1'b0; else d_arvalid = 1'b0;
   endtask

   // One 8-beat dcache write burst.
   task automatic writeBurst(input logic [31:0] addr);
      beat_t b;
      bit    seen;
      awQ.push_back(addr);
      for (int k = 0; k < 8; k++) begin
         b.data = 32'hA500_0000 | 32'(k);
         b.last = (k == 7);
         wQ.push_back(b);
      end
      d_awaddr = addr; d_awlen = 4'd7; d_awsize = 3'd2; d_awvalid = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge aclk);
         seen = d_awready;
      end
      if (!seen) checkOutput("awready_timeout", 0, 1);
      @(posedge aclk); #1;
      d_awvalid = 1'b0;
      awDone    = 1'b1;
      for (int k = 0; k < 8; k++) begin
         d_wdata = 32'hA500_0000 | 32'(k); d_wstrb = 4'hF;
         d_wlast = (k == 7); d_wvalid = 1'b1;
         seen = 1'b0;
         for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge aclk);
            seen = d_wready;
         end
         if (!seen) checkOutput("wready_timeout", 32'(k), 32'hFFFF_FFFF);
         @(posedge aclk); #1;
      end
      d_wvalid = 1'b0; d_wlast = 1'b0;
   endtask

   // Wait until every queued expectation has been consumed, then compare
   // what is left over (nothing, if all went well).
   task automatic waitDrain(input string name);
      int left;
      left = 1;
      for (int c = 0; c < 600 && left != 0; c++) begin
         @(negedge aclk);
         left = grantQ.size() + iBeatQ.size() + dBeatQ.size() + wQ.size() + awQ.size();
      end
      checkOutput(name, 32'(left), 0);
      @(posedge aclk); #1;
   endtask

   // Downstream slave: accepts AR at once and returns addr+4*beat data;
   // accepts AW at once, toggles wready every cycle, answers B BDELAY cycles
   // after the last W beat.
   initial begin : slaveModel
      logic            arHs, rHs, wHs, wLastHs, bHs;
      logic [31:0]     capAddr;
      logic [3:0]      capLen;
      logic [ID_W-1:0] capId;
      logic [31:0]     rdAddr;
      logic [3:0]      rdLen;
      int              beat;
      int              bDelay;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; m_rid = '0;
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
      rdAddr = '0; rdLen = '0; beat = 0; bDelay = 0;
      forever begin
         @(negedge aclk);
         arHs    = m_arvalid & m_arready;
         capAddr = m_araddr; capLen = m_arlen; capId = m_arid;
         rHs     = m_rvalid & m_rready;
         wHs     = m_wvalid & m_wready;
         wLastHs = wHs & m_wlast;
         bHs     = m_bvalid & m_bready;
         @(posedge aclk); #1;
         if (areset) begin
            m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
            m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
            bDelay = 0;
         end else begin
            m_arready = 1'b1;
            m_awready = 1'b1;
            m_wready  = ~m_wready;
            if (rHs) begin
               if (m_rlast) begin
                  m_rvalid = 1'b0; m_rlast = 1'b0;
               end else begin
                  beat++;
                  m_rdata = rdAddr + 32'(4 * beat);
                  m_rlast = (beat == int'(rdLen));
               end
            end
            if (arHs) begin
               rdAddr = capAddr; rdLen = capLen; beat = 0;
               m_rid = capId; m_rvalid = 1'b1; m_rdata = capAddr;
               m_rlast = (capLen == 4'd0);
            end
            if (bHs) m_bvalid = 1'b0;
            if (wLastHs) bDelay = BDELAY;
            else if (bDelay > 0) begin
               bDelay--;
               if (bDelay == 0) m_bvalid = 1'b1;
            end
         end
      end
   end

   // Monitor: pops the scoreboard queues on every DUT handshake.
   initial begin : monitor
      arExp_t ea;
      beat_t  eb;
      logic   prevI, prevD;
      prevI = 1'b0; prevD = 1'b0;
      forever begin
         @(negedge aclk);
         if (areset) begin
            prevI = 1'b0; prevD = 1'b0;
         end else begin
            if (m_arvalid && m_arready) begin
               if (grantQ.size() == 0) checkOutput("ar_unexpected", 1, 0);
               else begin
                  ea = grantQ.pop_front();
                  checkOutput("m_arid",   32'(m_arid), 32'(ea.id));
                  checkOutput("m_araddr", m_araddr, ea.addr);
                  checkOutput("m_arlen",  32'(m_arlen), 32'(ea.len));
               end
               if (m_araddr == 32'h0000_1020) d1020Cycle = cycle;
            end
            if (i_arready) begin
               iArreadyCount++;
               if (prevI) checkOutput("i_arready_pulse", 1, 0);
            end
            if (d_arready) begin
               dArreadyCycle = cycle;
               if (prevD) checkOutput("d_arready_pulse", 1, 0);
            end
            prevI = i_arready; prevD = d_arready;
            if (i_rvalid) checkOutput("d_rvalid_during_i", 32'(d_rvalid), 0);
            if (d_rvalid) checkOutput("i_rvalid_during_d", 32'(i_rvalid), 0);
            if (i_rvalid && i_rready) begin
               iBeatsSeen++;
               if (iBeatQ.size() == 0) checkOutput("i_r_unexpected", 1, 0);
               else begin
                  eb = iBeatQ.pop_front();
                  checkOutput("i_rdata", i_rdata, eb.data);
                  checkOutput("i_rlast", 32'(i_rlast), 32'(eb.last));
               end
            end
            if (d_rvalid && d_rready) begin
               if (dBeatQ.size() == 0) checkOutput("d_r_unexpected", 1, 0);
               else begin
                  eb = dBeatQ.pop_front();
                  checkOutput("d_rdata", d_rdata, eb.data);
                  checkOutput("d_rlast", 32'(d_rlast), 32'(eb.last));
               end
            end
            if (m_awvalid && m_awready) begin
               if (awQ.size() == 0) checkOutput("aw_unexpected", 1, 0);
               else begin
                  checkOutput("m_awaddr", m_awaddr, awQ.pop_front());
                  checkOutput("m_awid", 32'(m_awid), 1);
               end
            end
            if (m_wvalid && m_wready) begin
               wHsCount++;
               if (wQ.size() == 0) checkOutput("w_unexpected", 1, 0);
               else begin
                  eb = wQ.pop_front();
                  checkOutput("m_wdata", m_wdata, eb.data);
                  checkOutput("m_wlast", 32'(m_wlast), 32'(eb.last));
                  checkOutput("m_wid", 32'(m_wid), 1);
               end
            end
            if (d_bvalid && d_bready) begin
               bHsCount++;
               bHsCycle = cycle;
            end
         end
      end
   end

   // Test sequence.
   initial begin
      int base;
      compared = 0; mismatched = 0;
      iArreadyCount = 0; iBeatsSeen = 0; wHsCount = 0; bHsCount = 0;
      bHsCycle = -1; dArreadyCycle = -1; d1020Cycle = -1; awDone = 1'b0;
      areset = 1'b1;
      i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arvalid = 1'b0; i_rready = 1'b1;
      d_araddr = '0; d_arlen = '0; d_arsize = '0; d_arvalid = 1'b0; d_rready = 1'b1;
      d_awaddr = '0; d_awlen = '0; d_awsize = '0; d_awvalid = 1'b0;
      d_wdata = '0; d_wstrb = '0; d_wlast = 1'b0; d_wvalid = 1'b0; d_bready = 1'b1;

      // Reset state
      repeat (3) @(posedge aclk);
      #1;
      checkOutput("rst_i_arready", 32'(i_arready), 0);
      checkOutput("rst_d_arready", 32'(d_arready), 0);
      checkOutput("rst_m_arvalid", 32'(m_arvalid), 0);
      checkOutput("rst_m_arid",    32'(m_arid), 0);
      checkOutput("rst_m_araddr",  m_araddr, 0);
      checkOutput("rst_m_arlen",   32'(m_arlen), 0);
      checkOutput("rst_i_rvalid",  32'(i_rvalid), 0);
      checkOutput("rst_d_rvalid",  32'(d_rvalid), 0);
      checkOutput("rst_m_rready",  32'(m_rready), 0);
      checkOutput("rst_m_wvalid",  32'(m_wvalid), 0);
      checkOutput("rst_d_bvalid",  32'(d_bvalid), 0);
      areset = 1'b0;
      @(posedge aclk); #1;

      $display("[TB] lone icache read");
      base = iArreadyCount;
      expectGrant(4'd0, 32'h1FC0_0000, 4'd7);
      applyStimulus(0, 32'h1FC0_0000, 4'd7);
      waitDrain("drain_lone_i");
      checkOutput("i_arready_pulses", 32'(iArreadyCount - base), 1);

      $display("[TB] simultaneous icache and dcache");
      expectGrant(4'd1, 32'h0000_2000, 4'd3);
      expectGrant(4'd0, 32'h0000_2100, 4'd3);
      fork
         applyStimulus(1, 32'h0000_2000, 4'd3);
         applyStimulus(0, 32'h0000_2100, 4'd3);
      join
      waitDrain("drain_simul");

      $display("[TB] dcache flood with icache waiting");
      for (int k = 0; k < 4; k++) expectGrant(4'd1, 32'h0000_4000 + 32'(k * 64), 4'd1);
      expectGrant(4'd0, 32'h0000_5000, 4'd1);
      expectGrant(4'd1, 32'h0000_4100, 4'd1);
      fork
         for (int k = 0; k < 5; k++) applyStimulus(1, 32'h0000_4000 + 32'(k * 64), 4'd1);
         applyStimulus(0, 32'h0000_5000, 4'd1);
      join
      waitDrain("drain_starve");

      $display("[TB] write with same-line and other-line reads");
      wHsCount = 0; bHsCount = 0;
      expectGrant(4'd1, 32'h0000_1020, 4'd3);
      expectGrant(4'd1, 32'h0000_1014, 4'd1);
      fork
         writeBurst(32'h0000_1000);
         begin
            for (int c = 0; c < 100 && !awDone; c++) @(posedge aclk);
            #1;
            applyStimulus(1, 32'h0000_1020, 4'd3);
            for (int c = 0; c < 100 && dBeatQ.size() != 0; c++) @(posedge aclk);
            #1;
            applyStimulus(1, 32'h0000_1014, 4'd1);
         end
      join
      waitDrain("drain_write");
      checkOutput("w_handshakes", 32'(wHsCount), 8);
      checkOutput("b_handshakes", 32'(bHsCount), 1);
      checkOutput("other_line_before_b", 32'(d1020Cycle >= 0 && d1020Cycle < bHsCycle), 1);
      checkOutput("hazard_release_latency", 32'(dArreadyCycle - bHsCycle), 2);

      $display("[TB] reset during read burst");
      base = iBeatsSeen;
      expectGrant(4'd0, 32'h0000_6000, 4'd7);
      applyStimulus(0, 32'h0000_6000, 4'd7);
      for (int c = 0; c < 100 && iBeatsSeen < base + 2; c++) @(posedge aclk);
      @(posedge aclk); #1;
      areset = 1'b1;
      #1;
      checkOutput("mid_rst_i_rvalid",  32'(i_rvalid), 0);
      checkOutput("mid_rst_d_rvalid",  32'(d_rvalid), 0);
      checkOutput("mid_rst_m_rready",  32'(m_rready), 0);
      checkOutput("mid_rst_m_arvalid", 32'(m_arvalid), 0);
      checkOutput("mid_rst_i_arready", 32'(i_arready), 0);
      checkOutput("mid_rst_m_araddr",  m_araddr, 0);
      iBeatQ.delete();
      grantQ.delete();
      repeat (2) @(posedge aclk);
      #1;
      areset = 1'b0;
      @(posedge aclk); #1;
      expectGrant(4'd0, 32'h0000_3000, 4'd3);
      applyStimulus(0, 32'h0000_3000, 4'd3);
      waitDrain("drain_after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
